// File: rtl/fft_pkg.sv
// Shared FFT definitions: AGU state encoding, width/lane helpers and the bit-rotate
// used by every block that maps butterfly pairs onto in-place memory addresses.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } agu_state_e;

  function automatic int unsigned log2c(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  // Rotate the low w bits of v left by s (mod w); bits above w are returned as zero.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s,
                                       input int unsigned w);
    logic [31:0]  mask;
    logic [31:0]  vm;
    int unsigned  sh;
    mask = (w >= 32'd32) ? '1 : ((32'd1 << w) - 32'd1);
    vm   = v & mask;
    sh   = s % w;
    return ((vm << sh) | (vm >> (w - sh))) & mask;
  endfunction

endpackage

// File: rtl/fft_agu_lane.sv
// One butterfly lane: (stage, pair id) -> operand addresses and twiddle index.
// Purely combinational, zero latency, no flow control.
module fft_agu_lane
  import fft_pkg::*;
#(
  parameter int LOG2N   = 5,
  parameter int STAGE_W = 3,
  parameter int PAIR_W  = 4
) (
  input  logic [STAGE_W-1:0] i_stage,
  input  logic [PAIR_W-1:0]  i_pair,
  output logic [LOG2N-1:0]   o_addr1,
  output logic [LOG2N-1:0]   o_addr2,
  output logic [PAIR_W-1:0]  o_twiddle
);

  logic [PAIR_W:0] w_lim;

  assign o_addr1 = LOG2N'(rotl(32'({i_pair, 1'b0}), 32'(i_stage), LOG2N));
  assign o_addr2 = LOG2N'(rotl(32'({i_pair, 1'b1}), 32'(i_stage), LOG2N));

  // Twiddle keeps the low 'stage' bits of the pair id; stage never exceeds PAIR_W.
  assign w_lim     = {{PAIR_W{1'b0}}, 1'b1} << i_stage;
  assign o_twiddle = PAIR_W'({1'b0, i_pair} & (w_lim - {{PAIR_W{1'b0}}, 1'b1}));

endmodule

// File: rtl/fft_agu_seq.sv
// Radix-2 DIT FFT address sequencer: P butterflies/beat, first beat one cycle after start,
// registered beats hold under o_ready=0. FFT_AGU_STALL_CNT_EN adds a saturating stall counter.
module fft_agu_seq
  import fft_pkg::*;
#(
  parameter int N         = 32,
  parameter int P         = 1,
  parameter int STAGE_GAP = 0,
  localparam int LOG2N    = int'(log2c(N)),
  localparam int STAGE_W  = int'(log2c(LOG2N)),
  localparam int PAIR_W   = LOG2N - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  o_ready,
  output logic                  o_valid,
  output logic [P*LOG2N-1:0]    address1,
  output logic [P*LOG2N-1:0]    address2,
  output logic [P*PAIR_W-1:0]   twiddle_address,
  output logic [STAGE_W-1:0]    o_stage,
  output logic                  o_last_in_stage,
  output logic                  busy,
  output logic                  done
`ifdef FFT_AGU_STALL_CNT_EN
  , output logic [15:0]         stall_count
`endif
);

  localparam logic [PAIR_W-1:0]  LAST_BASE  = PAIR_W'(N / 2 - P);
  localparam logic [PAIR_W-1:0]  P_STEP     = PAIR_W'(P);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
  localparam logic [7:0]         GAP_LAST   = 8'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  agu_state_e            r_state, w_state_n;
  logic [STAGE_W-1:0]    r_stage, w_stage_n;
  logic [PAIR_W-1:0]     r_base, w_base_n;
  logic [7:0]            r_gap_cnt, w_gap_n;
  logic                  r_valid, w_valid_n;
  logic                  r_last, w_last_n;
  logic                  r_busy, w_busy_n;
  logic                  r_done, w_done_n;
  logic                  w_load;
  logic                  w_free;
  logic [P*LOG2N-1:0]    r_a1, r_a2, w_a1, w_a2;
  logic [P*PAIR_W-1:0]   r_tw, w_tw;
  logic [STAGE_W-1:0]    r_ostage;

  for (genvar k = 0; k < P; k++) begin : g_lane
    logic [PAIR_W-1:0] w_pair;
    assign w_pair = r_base + PAIR_W'(k);
    fft_agu_lane #(.LOG2N(LOG2N), .STAGE_W(STAGE_W), .PAIR_W(PAIR_W)) u_lane (
      .i_stage   (r_stage),
      .i_pair    (w_pair),
      .o_addr1   (w_a1[lane_lo(k, LOG2N) +: LOG2N]),
      .o_addr2   (w_a2[lane_lo(k, LOG2N) +: LOG2N]),
      .o_twiddle (w_tw[lane_lo(k, PAIR_W) +: PAIR_W])
    );
  end

  assign w_free = !r_valid || o_ready;

  always_comb begin
    w_state_n = r_state;
    w_stage_n = r_stage;
    w_base_n  = r_base;
    w_gap_n   = r_gap_cnt;
    w_valid_n = r_valid && !o_ready;
    w_last_n  = r_last;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n = ST_RUN;
          w_stage_n = '0;
          w_base_n  = '0;
          w_busy_n  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_free) begin
          w_load    = 1'b1;
          w_valid_n = 1'b1;
          w_last_n  = (r_base == LAST_BASE);
          if (r_base != LAST_BASE) begin
            w_base_n = r_base + P_STEP;
          end else if (r_stage == LAST_STAGE) begin
            w_state_n = ST_FLUSH;
          end else begin
            w_stage_n = r_stage + STAGE_W'(1);
            w_base_n  = '0;
            if (STAGE_GAP > 0) begin
              w_state_n = ST_GAP;
              w_gap_n   = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_n = ST_RUN;
        else                       w_gap_n   = r_gap_cnt + 8'd1;
      end
      ST_FLUSH: begin
        if (r_valid && o_ready) begin
          w_state_n = ST_IDLE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_stage   <= '0;
      r_base    <= '0;
      r_gap_cnt <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_a1      <= '0;
      r_a2      <= '0;
      r_tw      <= '0;
      r_ostage  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_stage   <= w_stage_n;
      r_base    <= w_base_n;
      r_gap_cnt <= w_gap_n;
      r_valid   <= w_valid_n;
      r_last    <= w_last_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      if (w_load) begin
        r_a1     <= w_a1;
        r_a2     <= w_a2;
        r_tw     <= w_tw;
        r_ostage <= r_stage;
      end
    end
  end

  assign o_valid         = r_valid;
  assign address1        = r_a1;
  assign address2        = r_a2;
  assign twiddle_address = r_tw;
  assign o_stage         = r_ostage;
  assign o_last_in_stage = r_last;
  assign busy            = r_busy;
  assign done            = r_done;

`ifdef FFT_AGU_STALL_CNT_EN
  logic        w_start_acc;
  logic [15:0] r_stall_cnt;

  assign w_start_acc = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           r_stall_cnt <= '0;
    else if (w_start_acc)                                r_stall_cnt <= '0;
    else if (r_valid && !o_ready && r_stall_cnt != '1)   r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fft_agu_seq.sv
// Directed bench for fft_agu_seq: three instances (N=8/P=1, N=16/P=2/gap 3, N=32/P=4).
module tb_fft_agu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // N=8, P=1, GAP=0
  logic       s8_start, s8_ready, s8_valid, s8_last, s8_busy, s8_done;
  logic [2:0] s8_a1, s8_a2;
  logic [1:0] s8_tw, s8_stage;
  // N=16, P=2, GAP=3
  logic       s16_start, s16_ready, s16_valid, s16_last, s16_busy, s16_done;
  logic [7:0] s16_a1, s16_a2;
  logic [5:0] s16_tw;
  logic [1:0] s16_stage;
  // N=32, P=4, GAP=0
  logic        s32_start, s32_ready, s32_valid, s32_last, s32_busy, s32_done;
  logic [19:0] s32_a1, s32_a2;
  logic [15:0] s32_tw;
  logic [2:0]  s32_stage;
`ifdef FFT_AGU_STALL_CNT_EN
  logic [15:0] s8_stall, s16_stall, s32_stall;
`endif

  fft_agu_seq #(.N(8), .P(1), .STAGE_GAP(0)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .o_ready(s8_ready), .o_valid(s8_valid),
    .address1(s8_a1), .address2(s8_a2), .twiddle_address(s8_tw), .o_stage(s8_stage),
    .o_last_in_stage(s8_last), .busy(s8_busy), .done(s8_done)
`ifdef FFT_AGU_STALL_CNT_EN
    , .stall_count(s8_stall)
`endif
  );

  fft_agu_seq #(.N(16), .P(2), .STAGE_GAP(3)) u_dut16 (
    .clk(clk), .reset(reset), .start(s16_start), .o_ready(s16_ready), .o_valid(s16_valid),
    .address1(s16_a1), .address2(s16_a2), .twiddle_address(s16_tw), .o_stage(s16_stage),
    .o_last_in_stage(s16_last), .busy(s16_busy), .done(s16_done)
`ifdef FFT_AGU_STALL_CNT_EN
    , .stall_count(s16_stall)
`endif
  );

  fft_agu_seq #(.N(32), .P(4), .STAGE_GAP(0)) u_dut32 (
    .clk(clk), .reset(reset), .start(s32_start), .o_ready(s32_ready), .o_valid(s32_valid),
    .address1(s32_a1), .address2(s32_a2), .twiddle_address(s32_tw), .o_stage(s32_stage),
    .o_last_in_stage(s32_last), .busy(s32_busy), .done(s32_done)
`ifdef FFT_AGU_STALL_CNT_EN
    , .stall_count(s32_stall)
`endif
  );

  int b8_a1[16], b8_a2[16], b8_tw[16], b8_last[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rotate left one bit at a time within an L-bit field.
  function automatic logic [31:0] m_rot(input int v, input int s, input int L);
    logic [31:0] r;
    logic [31:0] m;
    m = (32'd1 << L) - 32'd1;
    r = 32'(v) & m;
    for (int i = 0; i < s; i++) r = ((r << 1) | (r >> (L - 1))) & m;
    return r;
  endfunction

  function automatic logic [31:0] m_tw(input int p, input int s);
    return 32'(p) & ((32'd1 << s) - 32'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 transform with o_ready=1, optional 5-cycle stall on beat stall_beat,
  // optional start pulses while busy. Returns in the cycle where done is seen.
  task automatic run8(input int stall_beat, input bit inject, output int nb);
    int s, p, last_c;
    bit done_seen, stalled;
    logic [31:0] h1, h2, ht, hs;
    s8_start = 1'b1;
    tick();
    s8_start = 1'b0;
    chk("t8_accept_busy", 32'(s8_busy), 1);
    chk("t8_accept_valid", 32'(s8_valid), 0);
    nb = 0; s = 0; p = 0; last_c = -10; done_seen = 0; stalled = 0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      tick();
      s8_start = inject && (c >= 1) && (c < 5);
      if (s8_done) begin
        done_seen = 1;
        chk("t8_done_timing", 32'(c), 32'(last_c + 1));
        chk("t8_done_busy", 32'(s8_busy), 0);
        chk("t8_done_valid", 32'(s8_valid), 0);
      end else if (s8_valid) begin
        if (nb == stall_beat && !stalled) begin
          h1 = 32'(s8_a1); h2 = 32'(s8_a2); ht = 32'(s8_tw); hs = 32'(s8_stage);
          s8_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_valid", 32'(s8_valid), 1);
            chk("t2_hold_a1", 32'(s8_a1), h1);
            chk("t2_hold_a2", 32'(s8_a2), h2);
            chk("t2_hold_tw", 32'(s8_tw), ht);
            chk("t2_hold_stage", 32'(s8_stage), hs);
          end
          s8_ready = 1'b1;
          stalled  = 1;
        end
        chk("t8_a1", 32'(s8_a1), m_rot(2 * p, s, 3));
        chk("t8_a2", 32'(s8_a2), m_rot(2 * p + 1, s, 3));
        chk("t8_tw", 32'(s8_tw), m_tw(p, s));
        chk("t8_stage", 32'(s8_stage), 32'(s));
        chk("t8_last", 32'(s8_last), 32'(p == 3));
        if (nb < 16) begin
          b8_a1[nb] = int'(s8_a1); b8_a2[nb] = int'(s8_a2);
          b8_tw[nb] = int'(s8_tw); b8_last[nb] = int'(s8_last);
        end
        nb++;
        last_c = c;
        p++;
        if (p == 4) begin p = 0; s++; end
      end
    end
    s8_start = 1'b0;
    chk("t8_done_seen", 32'(done_seen), 1);
    if (stall_beat >= 0) chk("t2_stall_applied", 32'(stalled), 1);
  endtask

  initial begin
    int nb, s, p, pp, first_c, done_c, zeros, stalls;
    bit found, done_seen, prev_stall;
    logic [31:0] seen [5];
    logic [19:0] h1, h2;
    logic [15:0] ht;
    int l0a1, l0a2, l1a1, l1a2;

    reset = 1'b1;
    s8_start = 0; s16_start = 0; s32_start = 0;
    s8_ready = 1; s16_ready = 1; s32_ready = 1;
    repeat (2) tick();
    chk("rst_valid", 32'(s8_valid), 0);
    chk("rst_busy", 32'(s8_busy), 0);
    chk("rst_done", 32'(s8_done), 0);
    chk("rst_a1", 32'(s8_a1), 0);
    chk("rst_a2", 32'(s8_a2), 0);
    chk("rst_tw", 32'(s8_tw), 0);
    chk("rst_stage", 32'(s8_stage), 0);
    chk("rst_last", 32'(s8_last), 0);
    chk("rst16_a1", 32'(s16_a1), 0);
    chk("rst32_valid", 32'(s32_valid), 0);
    reset = 1'b0;
    tick();

    // 1: basic N=8 walk with hand-computed spot vectors
    run8(-1, 0, nb);
    chk("t1_beats", 32'(nb), 12);
    chk("t1_b0_a1", 32'(b8_a1[0]), 0);
    chk("t1_b0_a2", 32'(b8_a2[0]), 1);
    chk("t1_b0_tw", 32'(b8_tw[0]), 0);
    chk("t1_s1p1_a1", 32'(b8_a1[5]), 4);
    chk("t1_s1p1_a2", 32'(b8_a2[5]), 6);
    chk("t1_s1p1_tw", 32'(b8_tw[5]), 1);
    chk("t1_last_a1", 32'(b8_a1[11]), 3);
    chk("t1_last_a2", 32'(b8_a2[11]), 7);
    chk("t1_last_tw", 32'(b8_tw[11]), 3);
    chk("t1_last_flag", 32'(b8_last[11]), 1);
    chk("t1_mid_flag", 32'(b8_last[2]), 0);
`ifdef FFT_AGU_STALL_CNT_EN
    chk("t1_stall_count", 32'(s8_stall), 0);
`endif
    tick();
    chk("t1_done_width", 32'(s8_done), 0);

    // 2: five-cycle backpressure on beat 3
    run8(3, 0, nb);
    chk("t2_beats", 32'(nb), 12);
`ifdef FFT_AGU_STALL_CNT_EN
    chk("t2_stall_count", 32'(s8_stall), 5);
    tick();
    chk("t2_stall_hold", 32'(s8_stall), 5);
`else
    tick();
`endif

    // 5: start while busy is ignored; start in the done cycle relaunches
    run8(-1, 1, nb);
    chk("t5_beats_inject", 32'(nb), 12);
    run8(-1, 0, nb);
    chk("t5_beats_relaunch", 32'(nb), 12);
    chk("t5_relaunch_b0_a2", 32'(b8_a2[0]), 1);
    tick();

    // 4: reset during stage 1
    s8_start = 1'b1;
    tick();
    s8_start = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (s8_valid && s8_stage == 2'd1) found = 1;
    end
    chk("t4_reached_s1", 32'(found), 1);
    reset = 1'b1;
    #1;
    chk("t4_async_valid", 32'(s8_valid), 0);
    chk("t4_async_busy", 32'(s8_busy), 0);
    tick();
    reset = 1'b0;
    chk("t4_rst_valid", 32'(s8_valid), 0);
    chk("t4_rst_done", 32'(s8_done), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_no_done", 32'(s8_done), 0);
      chk("t4_idle_valid", 32'(s8_valid), 0);
    end
    run8(-1, 0, nb);
    chk("t4_replay_beats", 32'(nb), 12);
    chk("t4_replay_b0_a1", 32'(b8_a1[0]), 0);
    chk("t4_replay_b0_a2", 32'(b8_a2[0]), 1);
    tick();

    // 3: N=16, P=2, three-cycle gap between stages
    s16_start = 1'b1;
    tick();
    s16_start = 1'b0;
    nb = 0; s = 0; p = 0; first_c = -1; done_c = -1; zeros = 0;
    l0a1 = -1; l0a2 = -1; l1a1 = -1; l1a2 = -1;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      tick();
      if (s16_done) begin
        done_c = c;
      end else if (s16_valid) begin
        if (first_c < 0) begin
          first_c = c;
          l0a1 = int'(s16_a1[3:0]); l0a2 = int'(s16_a2[3:0]);
          l1a1 = int'(s16_a1[7:4]); l1a2 = int'(s16_a2[7:4]);
        end
        if (nb > 0 && p == 0) chk("t3_gap_len", 32'(zeros), 3);
        else if (nb > 0)      chk("t3_no_bubble", 32'(zeros), 0);
        zeros = 0;
        for (int k = 0; k < 2; k++) begin
          pp = p + k;
          chk("t3_a1", 32'(s16_a1[k*4 +: 4]), m_rot(2 * pp, s, 4));
          chk("t3_a2", 32'(s16_a2[k*4 +: 4]), m_rot(2 * pp + 1, s, 4));
          chk("t3_tw", 32'(s16_tw[k*3 +: 3]), m_tw(pp, s));
        end
        chk("t3_stage", 32'(s16_stage), 32'(s));
        chk("t3_last", 32'(s16_last), 32'(p + 2 == 8));
        nb++;
        p += 2;
        if (p == 8) begin p = 0; s++; end
      end else if (first_c >= 0) begin
        zeros++;
      end
    end
    chk("t3_beats", 32'(nb), 16);
    chk("t3_total_cycles", 32'(done_c - first_c), 25);
    chk("t3_b0_l0_a1", 32'(l0a1), 0);
    chk("t3_b0_l0_a2", 32'(l0a2), 1);
    chk("t3_b0_l1_a1", 32'(l1a1), 2);
    chk("t3_b0_l1_a2", 32'(l1a2), 3);
    chk("t3_done_busy", 32'(s16_busy), 0);
    tick();

    // 6: N=32, P=4 under random o_ready
    for (int i = 0; i < 5; i++) seen[i] = '0;
    s32_start = 1'b1;
    tick();
    s32_start = 1'b0;
    nb = 0; s = 0; p = 0; stalls = 0; prev_stall = 0; done_seen = 0;
    h1 = '0; h2 = '0; ht = '0;
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      tick();
      s32_ready = ($urandom_range(0, 3) != 0);
      if (s32_done) begin
        done_seen = 1;
      end else begin
        if (prev_stall) begin
          chk("t6_hold_valid", 32'(s32_valid), 1);
          chk("t6_hold_a1", 32'(s32_a1), 32'(h1));
          chk("t6_hold_a2", 32'(s32_a2), 32'(h2));
          chk("t6_hold_tw", 32'(s32_tw), 32'(ht));
        end
        if (s32_valid && !s32_ready) stalls++;
        if (s32_valid && s32_ready) begin
          for (int k = 0; k < 4; k++) begin
            pp = p + k;
            chk("t6_a1", 32'(s32_a1[k*5 +: 5]), m_rot(2 * pp, s, 5));
            chk("t6_a2", 32'(s32_a2[k*5 +: 5]), m_rot(2 * pp + 1, s, 5));
            chk("t6_tw", 32'(s32_tw[k*4 +: 4]), m_tw(pp, s));
            if (s < 5) begin
              seen[s][s32_a1[k*5 +: 5]] = 1'b1;
              seen[s][s32_a2[k*5 +: 5]] = 1'b1;
            end
          end
          chk("t6_stage", 32'(s32_stage), 32'(s));
          chk("t6_last", 32'(s32_last), 32'(p + 4 == 16));
          nb++;
          p += 4;
          if (p == 16) begin p = 0; s++; end
        end
        prev_stall = s32_valid && !s32_ready;
        h1 = s32_a1; h2 = s32_a2; ht = s32_tw;
      end
    end
    chk("t6_done_seen", 32'(done_seen), 1);
    chk("t6_beats", 32'(nb), 20);
    for (int i = 0; i < 5; i++) chk("t6_stage_cover", seen[i], 32'hFFFF_FFFF);
`ifdef FFT_AGU_STALL_CNT_EN
    chk("t6_stall_count", 32'(s32_stall), 32'(stalls));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
